// File: rtl/sum_accum_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sum_accum_pkg : burst-state enum and accumulator width helpers.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sum_accum_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Total wide enough that N full-scale sums never wrap.
  function automatic int acc_width(input int w, input int n);
    return w + $clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sum_accumulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sum_accumulator_if : result stream in, burst record out.                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sum_accumulator_if
  import sum_accum_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int ACC_W = acc_width(W, N),
  parameter int CNT_W = cnt_width(N)
);

  logic             valid_i;
  logic [W-1:0]     sum_i;
  logic             is_odd_i;
  logic             flush_i;
  logic             ready_o;
  logic             valid_o;
  logic             ready_i;
  logic [ACC_W-1:0] total_o;
  logic [CNT_W-1:0] odd_cnt_o;
  logic [CNT_W-1:0] beats_o;
  logic             err_o;

  modport master (
    output valid_i, sum_i, is_odd_i, flush_i, ready_i,
    input  ready_o, valid_o, total_o, odd_cnt_o, beats_o, err_o
  );

  modport slave (
    input  valid_i, sum_i, is_odd_i, flush_i, ready_i,
    output ready_o, valid_o, total_o, odd_cnt_o, beats_o, err_o
  );

endinterface
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sum_accumulator : sums N adder results per burst, counts odd results,   |
// | flags parity mismatches. Rev 1.0                                         |
// +--------------------------------------------------------------------------+
module sum_accumulator
  import sum_accum_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int ACC_W = acc_width(W, N),
  parameter int CNT_W = cnt_width(N)
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  sum_accumulator_if.slave bus
);

  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(N - 1);

  state_t           state_q,   state_d;
  logic [ACC_W-1:0] total_q,   total_d;
  logic [CNT_W-1:0] odd_cnt_q, odd_cnt_d;
  logic [CNT_W-1:0] beats_q,   beats_d;
  logic             err_q,     err_d;
  logic             accept;

  assign accept = bus.valid_i && (state_q == ACCUM);

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    odd_cnt_d = odd_cnt_q;
    beats_d   = beats_q;
    err_d     = err_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          total_d   = total_q + ACC_W'(bus.sum_i);
          odd_cnt_d = odd_cnt_q + CNT_W'(bus.is_odd_i);
          beats_d   = beats_q + CNT_W'(1);
          if (bus.is_odd_i != bus.sum_i[0]) err_d = 1'b1;
        end
        // A flush only closes a burst that holds at least one result.
        if ((accept && beats_q == C_LAST_BEAT) ||
            (bus.flush_i && (beats_q != '0 || accept))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          state_d   = ACCUM;
          total_d   = '0;
          odd_cnt_d = '0;
          beats_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      total_q   <= '0;
      odd_cnt_q <= '0;
      beats_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      odd_cnt_q <= odd_cnt_d;
      beats_q   <= beats_d;
      err_q     <= err_d;
    end
  end

  assign bus.ready_o   = (state_q == ACCUM);
  assign bus.valid_o   = (state_q == DONE);
  assign bus.total_o   = total_q;
  assign bus.odd_cnt_o = odd_cnt_q;
  assign bus.beats_o   = beats_q;
  assign bus.err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sum_accumulator : directed burst table, corner sequences and random  |
// | traffic against a queue-based reference. Rev 1.0                         |
// +--------------------------------------------------------------------------+
module tb_sum_accumulator;

  localparam int W = 8;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  sum_accumulator_if #(.W(W), .N(N)) bus ();

  sum_accumulator #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed burst: sums packed byte 0 first; flush asserted on last beat.
  typedef struct {
    int          nb;
    logic [31:0] sums;
    bit          flush;
    int          exp_total;
    int          exp_odd;
  } burst_t;

  burst_t tbl[5];

  // Reference: the open burst is just the list of accepted results.
  int q_sum[$];
  bit q_odd[$];
  bit m_pend;
  bit m_err;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_total();
    int t = 0;
    foreach (q_sum[i]) t += q_sum[i];
    return t;
  endfunction

  function automatic int m_odds();
    int c = 0;
    foreach (q_odd[i]) c += int'(q_odd[i]);
    return c;
  endfunction

  // Called at a negedge; returns at the next negedge.
  task automatic send_beat(input int s, input bit odd, input bit fl);
    bus.valid_i  = 1'b1;
    bus.sum_i    = W'(s);
    bus.is_odd_i = odd;
    bus.flush_i  = fl;
    @(negedge clk);
    bus.valid_i  = 1'b0;
    bus.flush_i  = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] s;
    bit         odd;
    bit         hold;
    bit         acc;
    int         part;

    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.valid_i = 1'b0; bus.sum_i = '0; bus.is_odd_i = 1'b0;
    bus.flush_i = 1'b0; bus.ready_i = 1'b1;

    tbl[0] = '{4, {8'd4,   8'd11,  8'd2,   8'd0  }, 1'b0, 17,   1};
    tbl[1] = '{2, {8'd0,   8'd0,   8'd9,   8'd6  }, 1'b1, 15,   1};
    tbl[2] = '{4, {8'd255, 8'd255, 8'd255, 8'd255}, 1'b0, 1020, 4};
    tbl[3] = '{3, {8'd0,   8'd5,   8'd3,   8'd1  }, 1'b1, 9,    3};
    tbl[4] = '{1, {8'd0,   8'd0,   8'd0,   8'd7  }, 1'b1, 7,    1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", int'(bus.ready_o), 1);
    check("rst_valid", int'(bus.valid_o), 0);
    check("rst_total", int'(bus.total_o), 0);
    check("rst_beats", int'(bus.beats_o), 0);
    check("rst_err",   int'(bus.err_o),   0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed bursts, downstream always ready
    foreach (tbl[k]) begin
      part = 0;
      for (int b = 0; b < tbl[k].nb; b++) begin
        s = tbl[k].sums[8*b +: 8];
        send_beat(int'(s), s[0], tbl[k].flush && (b == tbl[k].nb - 1));
        part += int'(s);
        if (b != tbl[k].nb - 1) begin
          check("tbl_ready_mid", int'(bus.ready_o), 1);
          check("tbl_total_mid", int'(bus.total_o), part);
        end
      end
      check("tbl_valid", int'(bus.valid_o),   1);
      check("tbl_ready", int'(bus.ready_o),   0);
      check("tbl_total", int'(bus.total_o),   tbl[k].exp_total);
      check("tbl_odd",   int'(bus.odd_cnt_o), tbl[k].exp_odd);
      check("tbl_beats", int'(bus.beats_o),   tbl[k].nb);
      check("tbl_err",   int'(bus.err_o),     0);
      @(negedge clk);
      check("tbl_ready_back", int'(bus.ready_o), 1);
      check("tbl_valid_drop", int'(bus.valid_o), 0);
      check("tbl_total_clr",  int'(bus.total_o), 0);
      check("tbl_beats_clr",  int'(bus.beats_o), 0);
    end

    // Flush on an empty burst is ignored
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("eflush_valid", int'(bus.valid_o), 0);
    check("eflush_ready", int'(bus.ready_o), 1);
    check("eflush_beats", int'(bus.beats_o), 0);

    // Downstream stall: record held, input pulses refused
    bus.ready_i = 1'b0;
    for (int b = 1; b <= 4; b++) send_beat(b, b[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", int'(bus.valid_o), 1);
      check("stall_total", int'(bus.total_o), 10);
      check("stall_beats", int'(bus.beats_o), 4);
      bus.valid_i = 1'b1; bus.sum_i = 8'd200; bus.is_odd_i = 1'b0;
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    check("stall_release_valid", int'(bus.valid_o), 0);
    check("stall_release_total", int'(bus.total_o), 0);
    check("stall_release_beats", int'(bus.beats_o), 0);

    // Parity mismatch is sticky across bursts until reset
    send_beat(11, 1'b0, 1'b0);
    check("err_set", int'(bus.err_o), 1);
    send_beat(2, 1'b0, 1'b0);
    send_beat(4, 1'b0, 1'b0);
    send_beat(6, 1'b0, 1'b0);
    check("err_burst_total", int'(bus.total_o), 23);
    @(negedge clk);
    for (int b = 0; b < 4; b++) send_beat(3, 1'b1, 1'b0);
    check("err_sticky", int'(bus.err_o), 1);
    @(negedge clk);
    check("err_sticky2", int'(bus.err_o), 1);
    reset_pulse();
    check("err_cleared", int'(bus.err_o), 0);

    // Asynchronous reset in the middle of a burst
    send_beat(255, 1'b1, 1'b0);
    send_beat(255, 1'b1, 1'b0);
    check("mid_total", int'(bus.total_o), 510);
    #2 rst_n = 1'b0;
    #1;
    check("arst_total", int'(bus.total_o), 0);
    check("arst_beats", int'(bus.beats_o), 0);
    check("arst_ready", int'(bus.ready_o), 1);
    check("arst_valid", int'(bus.valid_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic against the reference
    q_sum.delete(); q_odd.delete();
    m_pend = 1'b0; m_err = 1'b0; hold = 1'b0;
    s = '0; odd = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      check("rnd_ready", int'(bus.ready_o),   int'(!m_pend));
      check("rnd_valid", int'(bus.valid_o),   int'(m_pend));
      check("rnd_total", int'(bus.total_o),   m_total());
      check("rnd_odd",   int'(bus.odd_cnt_o), m_odds());
      check("rnd_beats", int'(bus.beats_o),   q_sum.size());
      check("rnd_err",   int'(bus.err_o),     int'(m_err));

      if (!hold) begin
        bus.valid_i = ($urandom_range(0, 3) != 0);
        s   = 8'($urandom_range(0, 255));
        odd = ($urandom_range(0, 39) == 0) ? ~s[0] : s[0];
      end
      bus.sum_i    = s;
      bus.is_odd_i = odd;
      bus.flush_i  = ($urandom_range(0, 7) == 0);
      bus.ready_i  = ($urandom_range(0, 2) != 0);

      acc  = bus.valid_i && !m_pend;
      hold = bus.valid_i && !acc;
      if (!m_pend) begin
        if (acc) begin
          q_sum.push_back(int'(s));
          q_odd.push_back(odd);
          if (odd != s[0]) m_err = 1'b1;
        end
        if ((acc && q_sum.size() == N) || (bus.flush_i && q_sum.size() > 0))
          m_pend = 1'b1;
      end else if (bus.ready_i) begin
        m_pend = 1'b0;
        q_sum.delete();
        q_odd.delete();
      end
      @(negedge clk);
    end
    check("rnd_final_total", int'(bus.total_o), m_total());
    check("rnd_final_err",   int'(bus.err_o),   int'(m_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the adder stage: accepts a stream of (sum, is_odd) results over a valid/ready handshake, accumulates N results per burst into a widened running total, counts odd results, and checks the parity flag against the sum LSB. Presents each completed burst as one (total, odd count) record on a valid/ready output toward the next stage.

## Interface
- W, 8, width of incoming sum (matches adder W)
- N, 4, results per burst; legal range 2..255
- ACC_W, W + $clog2(N), total width; sized so a full burst cannot overflow
- CNT_W, $clog2(N+1), width of beat and odd counters
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- valid_i  input  1  upstream result valid
- sum_i  input  W  adder sum
- is_odd_i  input  1  adder parity flag
- flush_i  input  1  close current burst early
- ready_o  output  1  block accepts a result this cycle
- valid_o  output  1  burst record valid
- ready_i  input  1  downstream accepts record
- total_o  output  ACC_W  sum of the burst's results, zero-extended
- odd_cnt_o  output  CNT_W  number of accepted results with is_odd_i=1
- beats_o  output  CNT_W  results in this burst (N, or fewer if flushed)
- err_o  output  1  sticky parity-mismatch flag

## Operation
- Two states: ACCUM, DONE. ready_o = (state==ACCUM); valid_o = (state==DONE). Both pure state decodes.
- Reset (rst_n=0, asynchronous): state ACCUM, total/odd_cnt/beats = 0, err_o = 0. During and after reset: valid_o=0, ready_o=1.
- ACCUM, accept = valid_i && ready_o: total += zero-extend(sum_i); odd_cnt += is_odd_i; beats += 1; if is_odd_i != sum_i[0], err_o <= 1.
- ACCUM -> DONE when accept and beats==N-1 (the Nth result), or when flush_i=1 and (beats>0 or accept).
- flush_i with beats==0 and no accept: ignored, stay ACCUM.
- flush_i coincident with accept: that result is included, then DONE.
- flush_i in DONE: ignored.
- DONE: total_o/odd_cnt_o/beats_o hold stable; valid_i ignored (ready_o=0). DONE -> ACCUM when ready_i=1; total/odd_cnt/beats clear to 0 on that edge.
- err_o stays set until reset; not cleared by burst completion.
- Unsigned arithmetic only; no saturation needed given ACC_W.

## Timing
- Result accepted on edge where valid_i && ready_o; contribution visible on total_o from next cycle.
- Record latency: valid_o rises the cycle after the burst-closing accept/flush edge.
- Output throughput: one idle input cycle minimum per burst (DONE lasts ≥1 cycle); if ready_i is held high, DONE lasts exactly 1 cycle.
- Upstream must hold sum_i/is_odd_i/valid_i stable until accepted; downstream may stall indefinitely via ready_i.
- Reset mid-burst or mid-DONE discards partial totals and any pending record; no output of the interrupted burst.
- Outputs total_o/odd_cnt_o/beats_o are direct register outputs; no combinational path from inputs to any output.

## Structure
- Shared package sum_accum_pkg: state enum (ACCUM, DONE), ACC_W/CNT_W derivation function reused by the adder bench and downstream stages.
- Single module; no sub-module warranted (counters and FSM are small and share one enable).

## Test plan
- N=4, feed sums 0,2,11,4 with correct parity, ready_i=1 -> one record: total_o=17, odd_cnt_o=1, beats_o=4, err_o=0; ready_o low exactly one cycle.
- Feed 6 then 9 (is_odd 0,1), flush_i with second beat -> total_o=15, odd_cnt_o=1, beats_o=2.
- flush_i with no accepted beats -> no state change, valid_o stays 0.
- Burst complete with ready_i=0 for 5 cycles -> valid_o held, outputs stable, valid_i pulses not accepted; release -> next burst starts from 0.
- Sum 11 with is_odd_i=0 -> err_o=1 next cycle, stays 1 across following bursts until rst_n pulse.
- Assert rst_n=0 mid-burst after sums 255,255 (W=8) -> outputs 0 immediately, ready_o=1; N=4 bursts of 255 -> total_o=1020 without wrap.
